// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift operation encoding used by the operand
// path, the pipelined shifter and its handshake interface.
package alu_pkg;

    // Encoding chosen so bit 0 selects "rightward" and bit 1 with bit 0
    // selects arithmetic fill; PASS sits in the otherwise unused slot.
    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_PASS = 2'b10,
        SHIFT_SRA  = 2'b11
    } shift_op_t;

    // Number of shifter stages (and shamt width) for an operand width.
    function automatic int shift_stages(int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Valid/ready handshake bundle for the pipelined shifter.
// Upstream side: i_valid/i_ready with operand, amount and op.
// Downstream side: o_valid/o_ready with the shifted result.
interface pipelined_shifter_if #(
    parameter int N = 32
);
    import alu_pkg::*;

    localparam int S = shift_stages(N);

    logic          i_valid;
    logic          i_ready;
    logic [N-1:0]  in;
    logic [S-1:0]  shamt;
    shift_op_t     op;
    logic          o_valid;
    logic          o_ready;
    logic [N-1:0]  out;

    // Environment view: produces operations and consumes results.
    modport master (
        output i_valid, in, shamt, op, o_ready,
        input  i_ready, o_valid, out
    );

    // Shifter view.
    modport slave (
        input  i_valid, in, shamt, op, o_ready,
        output i_ready, o_valid, out
    );

endinterface

// File: rtl/shifter_stage.sv
// One combinational barrel-shifter stage: shifts by the fixed amount 2^K
// when enabled, in the direction and fill selected by op. SRA fills with
// the original operand sign bit carried alongside the data, since
// after earlier right shifts the current MSB may already be fill.
module shifter_stage
    import alu_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0] d,
    input  logic         en,
    input  shift_op_t    op,
    input  logic         sign,
    output logic [N-1:0] q
);

    localparam int AMT = 2 ** K;

    // Fixed-distance shift; disabled stage or PASS leaves data untouched.
    always_comb begin
        q = d;
        if (en) begin
            case (op)
                SHIFT_SLL:  q = {d[N-1-AMT:0], {AMT{1'b0}}};
                SHIFT_SRL:  q = {{AMT{1'b0}}, d[N-1:AMT]};
                SHIFT_SRA:  q = {{AMT{sign}}, d[N-1:AMT]};
                SHIFT_PASS: q = d;
                default:    q = d;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(N) registered stages, stage k applying a
// conditional shift by 2^k. Each stage has an elastic valid/ready slot so
// a stalled consumer lets bubbles collapse until the pipe holds S ops.
// The last stage register drives the outputs directly (registered out).
module pipelined_shifter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipelined_shifter_if.slave  bus
);

    localparam int S = shift_stages(N);

    // Everything a stage slot carries: the partially shifted data plus the
    // control needed by the stages still ahead of it.
    typedef struct packed {
        logic         vld;
        logic         sign;
        shift_op_t    op;
        logic [S-1:0] shamt;
        logic [N-1:0] data;
    } stage_t;

    stage_t       src      [S];  // input presented to stage k
    stage_t       nxt      [S];  // value stage k would capture
    stage_t       pipe     [S];  // stage registers
    logic [N-1:0] nxt_data [S];
    logic         rdy      [S];  // stage k may load this cycle

    // ---- stage 0 input: upstream port, sign taken from the raw operand
    assign src[0] = '{
        vld:   bus.i_valid,
        sign:  bus.in[N-1],
        op:    bus.op,
        shamt: bus.shamt,
        data:  bus.in
    };

    // ---- stages 1..S-1 take their input from the previous register
    for (genvar k = 1; k < S; k++) begin : g_link
        assign src[k] = pipe[k-1];
    end

    // ---- shift datapath for every stage
    for (genvar k = 0; k < S; k++) begin : g_stage
        shifter_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .d    (src[k].data),
            .en   (src[k].shamt[k]),
            .op   (src[k].op),
            .sign (src[k].sign),
            .q    (nxt_data[k])
        );

        assign nxt[k] = '{
            vld:   src[k].vld,
            sign:  src[k].sign,
            op:    src[k].op,
            shamt: src[k].shamt,
            data:  nxt_data[k]
        };
    end

    // Backward ready chain: a slot may load if it is empty or its occupant
    // moves on this cycle. Computed top-down in one pass so the chain
    // from o_ready to i_ready is a plain combinational ripple.
    always_comb begin
        rdy[S-1] = !pipe[S-1].vld || bus.o_ready;
        for (int k = S - 2; k >= 0; k--) begin
            rdy[k] = !pipe[k].vld || rdy[k+1];
        end
    end

    // Stage registers: reset discards all in-flight work; a loading stage
    // takes the upstream valid, and data only moves when that is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < S; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (rdy[k]) begin
                    if (src[k].vld) begin
                        pipe[k] <= nxt[k];
                    end else begin
                        pipe[k].vld <= 1'b0;
                    end
                end
            end
        end
    end

    // ---- output boundary: last stage register is the result port
    assign bus.i_ready = rdy[0];
    assign bus.o_valid = pipe[S-1].vld;
    assign bus.out     = pipe[S-1].data;

endmodule
